// File: rtl/core_ifu_fetch_buf_pkg.sv
// rtl/core_ifu_fetch_buf_pkg.sv - shared widths, reset PC and response classification for the fetch buffer
package core_ifu_fetch_buf_pkg;

  localparam int          CORE_PC_WIDTH   = 32;
  localparam int          CORE_INST_WIDTH = 32;
  localparam logic [31:0] CORE_RESET_PC   = 32'h8000_0000;
  localparam int          CORE_IBUF_DEPTH = 4;

  // What an incoming memory response does to the buffer state.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_DROP,
    RSP_FILL,
    RSP_ERR
  } rsp_act_e;

endpackage

// File: rtl/core_ifu_fetch_buf_entries.sv
// rtl/core_ifu_fetch_buf_entries.sv - DEPTH x {pc, inst, filled} storage with alloc/fill write ports
module core_ifu_fetch_buf_entries
  import core_ifu_fetch_buf_pkg::*;
#(
  parameter int PC_WIDTH   = CORE_PC_WIDTH,
  parameter int INST_WIDTH = CORE_INST_WIDTH,
  parameter int DEPTH      = CORE_IBUF_DEPTH,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_alloc_en,
  input  logic [AW-1:0]         i_alloc_idx,
  input  logic [PC_WIDTH-1:0]   i_alloc_pc,
  input  logic                  i_fill_en,
  input  logic [AW-1:0]         i_fill_idx,
  input  logic [INST_WIDTH-1:0] i_fill_inst,
  input  logic [AW-1:0]         i_rd_idx,
  output logic [PC_WIDTH-1:0]   o_rd_pc,
  output logic [INST_WIDTH-1:0] o_rd_inst,
  output logic                  o_rd_filled
);

  logic [PC_WIDTH-1:0]   r_pc     [DEPTH];
  logic [INST_WIDTH-1:0] r_inst   [DEPTH];
  logic [DEPTH-1:0]      r_filled;

  // Alloc and fill never target the same slot: fill only lands on an older, already allocated entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
      r_filled <= '0;
    end else begin
      if (i_alloc_en) begin
        r_pc[i_alloc_idx]     <= i_alloc_pc;
        r_filled[i_alloc_idx] <= 1'b0;
      end
      if (i_fill_en) begin
        r_inst[i_fill_idx]   <= i_fill_inst;
        r_filled[i_fill_idx] <= 1'b1;
      end
    end
  end

  assign o_rd_pc     = r_pc[i_rd_idx];
  assign o_rd_inst   = r_inst[i_rd_idx];
  assign o_rd_filled = r_filled[i_rd_idx];

endmodule

// File: rtl/core_ifu_fetch_buf.sv
// rtl/core_ifu_fetch_buf.sv - pipelined instruction fetch front-end with in-order response buffer
module core_ifu_fetch_buf
  import core_ifu_fetch_buf_pkg::*;
#(
  parameter int                 PC_WIDTH   = CORE_PC_WIDTH,
  parameter int                 INST_WIDTH = CORE_INST_WIDTH,
  parameter int                 DEPTH      = CORE_IBUF_DEPTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = PC_WIDTH'(CORE_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pipe_flush_req,
  input  logic [PC_WIDTH-1:0]   i_flush_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PC_WIDTH-1:0]   mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [INST_WIDTH-1:0] mem_rsp_inst,
  output logic                  valid_out,
  input  logic                  ready_out,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [PC_WIDTH-1:0]   o_pc
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int PW1 = PW + 1;

  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PW-1:0]       r_alloc, r_fill, r_rd, r_drop_cnt;

  logic [PW-1:0]       w_used, w_pending, w_flush_drop;
  logic [PW1-1:0]      w_inflight;
  logic                w_issue, w_pop, w_head_filled, w_fill_en;
  rsp_act_e            w_rsp_act;

  assign w_used     = r_alloc - r_rd;
  assign w_pending  = r_alloc - r_fill;
  // Everything the memory still owes us, live or stale; this bounds outstanding requests.
  assign w_inflight = PW1'(w_pending) + PW1'(r_drop_cnt);

  assign mem_req_valid = rst_n && !i_pipe_flush_req && (w_used < PW'(DEPTH))
                         && (w_inflight < PW1'(DEPTH));
  assign mem_req_addr  = r_fetch_pc;
  assign w_issue       = mem_req_valid && mem_req_ready;

  assign valid_out = (w_used != '0) && w_head_filled;
  assign w_pop     = valid_out && ready_out && !i_pipe_flush_req;

  always_comb begin
    w_rsp_act = RSP_NONE;
    if (mem_rsp_valid) begin
      if (r_drop_cnt != '0)     w_rsp_act = RSP_DROP;
      else if (w_pending != '0) w_rsp_act = RSP_FILL;
      else                      w_rsp_act = RSP_ERR;
    end
  end

  assign w_fill_en    = (w_rsp_act == RSP_FILL) && !i_pipe_flush_req;
  assign w_flush_drop = r_drop_cnt + w_pending
                        - PW'(mem_rsp_valid && (w_inflight != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_drop_cnt <= '0;
    end else if (i_pipe_flush_req) begin
      r_fetch_pc <= i_flush_pc;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_rd       <= '0;
      r_drop_cnt <= w_flush_drop;
    end else begin
      if (w_issue) begin
        r_alloc    <= r_alloc + PW'(1);
        r_fetch_pc <= r_fetch_pc + PC_WIDTH'(4);
      end
      case (w_rsp_act)
        RSP_DROP: r_drop_cnt <= r_drop_cnt - PW'(1);
        RSP_FILL: r_fill     <= r_fill + PW'(1);
        default: ;
      endcase
      if (w_pop) r_rd <= r_rd + PW'(1);
    end
  end

  a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n) w_rsp_act != RSP_ERR);

  core_ifu_fetch_buf_entries #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_entries (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alloc_en  (w_issue),
    .i_alloc_idx (r_alloc[AW-1:0]),
    .i_alloc_pc  (r_fetch_pc),
    .i_fill_en   (w_fill_en),
    .i_fill_idx  (r_fill[AW-1:0]),
    .i_fill_inst (mem_rsp_inst),
    .i_rd_idx    (r_rd[AW-1:0]),
    .o_rd_pc     (o_pc),
    .o_rd_inst   (o_inst),
    .o_rd_filled (w_head_filled)
  );

endmodule

// File: tb/tb_core_ifu_fetch_buf.sv
// tb/tb_core_ifu_fetch_buf.sv - directed and randomized checks of core_ifu_fetch_buf against a queue model
module tb_core_ifu_fetch_buf;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_pipe_flush_req;
  logic [31:0] i_flush_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_inst;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  always #5 clk = ~clk;

  core_ifu_fetch_buf dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_pipe_flush_req (i_pipe_flush_req),
    .i_flush_pc       (i_flush_pc),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_inst     (mem_rsp_inst),
    .valid_out        (valid_out),
    .ready_out        (ready_out),
    .o_inst           (o_inst),
    .o_pc             (o_pc)
  );

  // Instructions fetched since the last flush/reset that the consumer has not taken yet.
  typedef struct { logic [31:0] pc; bit ret; } exp_t;
  // Requests the memory has accepted and still owes a response for.
  typedef struct { logic [31:0] addr; bit stale; int due; } mreq_t;

  exp_t        exp_q[$];
  mreq_t       mem_q[$];
  int          checks  = 0;
  int          errors  = 0;
  int          cyc     = 0;
  int          rsp_pct = 100;
  int          lat_max = 1;
  logic [31:0] next_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic mark_returned();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (!exp_q[i].ret) begin
        exp_q[i].ret = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    i_pipe_flush_req = 1'b0;
    i_flush_pc       = '0;
    mem_req_ready    = 1'b0;
    mem_rsp_valid    = 1'b0;
    mem_rsp_inst     = '0;
    ready_out        = 1'b0;
    #1;
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_o_pc", o_pc, 32'd0);
    chk("rst_o_inst", o_inst, 32'd0);
    exp_q.delete();
    mem_q.delete();
    next_pc = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit fl, input logic [31:0] fpc, input bit rdo, input bit mrr, input bit rsp_ok);
    bit    rsp, exp_req, exp_vld;
    mreq_t m;
    rsp = rsp_ok && (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < rsp_pct);
    i_pipe_flush_req = fl;
    i_flush_pc       = fpc;
    ready_out        = rdo;
    mem_req_ready    = mrr;
    mem_rsp_valid    = rsp;
    mem_rsp_inst     = rsp ? mem_word(mem_q[0].addr) : $urandom;
    #1;
    exp_req = !fl && (exp_q.size() < DEPTH) && (mem_q.size() < DEPTH);
    chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_req));
    if (exp_req) chk("mem_req_addr", mem_req_addr, next_pc);
    exp_vld = (exp_q.size() > 0) && exp_q[0].ret;
    chk("valid_out", 32'(valid_out), 32'(exp_vld));
    if (exp_vld) begin
      chk("o_pc", o_pc, exp_q[0].pc);
      chk("o_inst", o_inst, mem_word(exp_q[0].pc));
    end
    if (rsp) begin
      m = mem_q.pop_front();
      if (!m.stale && !fl) mark_returned();
    end
    if (exp_vld && rdo && !fl) void'(exp_q.pop_front());
    if (exp_req && mrr) begin
      mem_q.push_back('{next_pc, 1'b0, cyc + int'($urandom_range(lat_max, 1))});
      exp_q.push_back('{next_pc, 1'b0});
      next_pc += 32'd4;
    end
    if (fl) begin
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      exp_q.delete();
      next_pc = fpc;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    do_reset();
    rsp_pct = 100;
    lat_max = 1;
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (3)  step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    repeat (4)  step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    repeat (3)  step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h8000_0100, 1'b1, 1'b1, 1'b0);
    repeat (8)  step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
    // Steady stream: this flush collides with a response and a head handshake.
    step(1'b1, 32'h8000_0180, 1'b1, 1'b1, 1'b1);
    repeat (2)  step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h8000_0200, 1'b1, 1'b1, 1'b0);
    repeat (12) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

    for (int b = 0; b < 6; b++) begin
      rsp_pct = $urandom_range(100, 20);
      lat_max = $urandom_range(5, 1);
      repeat (500)
        step($urandom_range(99) < 4, $urandom & 32'hFFFF_FFFC,
             $urandom_range(99) < 70, $urandom_range(99) < 70, 1'b1);
    end

    // Asynchronous reset in the middle of traffic.
    do_reset();
    rsp_pct = 80;
    lat_max = 3;
    repeat (60)
      step($urandom_range(99) < 4, $urandom & 32'hFFFF_FFFC,
           $urandom_range(99) < 70, $urandom_range(99) < 70, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
